// File: rtl/wb_arbiter_pkg.sv
// Shared register-file defines and writeback-arbiter package.
// The defines are guarded so that several files can pull them in safely.
`ifndef WB_ARBITER_DEFINES
`define WB_ARBITER_DEFINES
`define RegIdWidth    5
`define RegWidth      32
`define RegCnt        32
`define WbFifoDepth   2
`define WbStarveLimit 4
`endif

package wb_arbiter_pkg;

  localparam int unsigned REG_ID_WIDTH    = `RegIdWidth;
  localparam int unsigned REG_WIDTH       = `RegWidth;
  localparam int unsigned REG_CNT         = `RegCnt;
  localparam int unsigned WB_FIFO_DEPTH   = `WbFifoDepth;
  localparam int unsigned WB_STARVE_LIMIT = `WbStarveLimit;
  localparam int unsigned STARVE_W        = $clog2(WB_STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_EXU  = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// LSU writeback buffer: circular FIFO of (rd, wdata) pairs with registered
// occupancy; pointers wrap modulo DEPTH so non-power-of-two depths work.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = WB_FIFO_DEPTH,
  parameter int ADDR_WIDTH = REG_ID_WIDTH,
  parameter int DATA_WIDTH = REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0] push_wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_rd,
  output logic [DATA_WIDTH-1:0] head_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem_rd_r    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_wdata_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full       = (count_r == CNT_W'(DEPTH));
  assign empty      = (count_r == {CNT_W{1'b0}});
  assign push_ok_s  = push && !full;
  assign pop_ok_s   = pop && !empty;
  assign head_rd    = mem_rd_r[rd_ptr_r];
  assign head_wdata = mem_wdata_r[rd_ptr_r];

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_rd_r[wr_ptr_r]    <= push_rd;
      mem_wdata_r[wr_ptr_r] <= push_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: EXU has priority, LSU results are buffered
// and forced through after a starvation limit. WB_BYPASS_EN adds forwarding.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = `RegIdWidth,
  parameter int DATA_WIDTH = `RegWidth,
  parameter int FIFO_DEPTH = `WbFifoDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  fwd1_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd2_data,
`endif
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] RD_ZERO = {ADDR_WIDTH{1'b0}};

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [ADDR_WIDTH-1:0] head_rd_s;
  logic [DATA_WIDTH-1:0] head_wdata_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  head_starved_s;
  grant_e                grant_s;
  logic [STARVE_W-1:0]   starve_r;
  logic                  rf_wen_r;
  logic [ADDR_WIDTH-1:0] rf_rd_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;

  wb_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_rd    (lsu_rd),
    .push_wdata (lsu_wdata),
    .pop        (pop_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .head_rd    (head_rd_s),
    .head_wdata (head_wdata_s)
  );

  // Single-winner grant; both ready outputs are held low during reset.
  always_comb begin
    head_starved_s = 1'b0;
    grant_s        = GRANT_NONE;
    if (!fifo_empty_s && (starve_r == STARVE_W'(WB_STARVE_LIMIT))) begin
      head_starved_s = 1'b1;
    end else begin
      head_starved_s = 1'b0;
    end
    if (!rst_n) begin
      grant_s = GRANT_NONE;
    end else if (head_starved_s) begin
      grant_s = GRANT_FIFO;
    end else if (exu_valid) begin
      grant_s = GRANT_EXU;
    end else if (!fifo_empty_s) begin
      grant_s = GRANT_FIFO;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  assign exu_ready = rst_n && !head_starved_s;
  assign lsu_ready = rst_n && !fifo_full_s;
  assign push_s    = lsu_valid && lsu_ready;
  assign pop_s     = (grant_s == GRANT_FIFO);
  assign busy      = !fifo_empty_s;

  // Cycles the buffered head has been passed over, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (fifo_empty_s || pop_s) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (starve_r != STARVE_W'(WB_STARVE_LIMIT)) begin
      starve_r <= starve_r + STARVE_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Registered write port; writes to x0 are consumed without a write pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_r   <= 1'b0;
      rf_rd_r    <= RD_ZERO;
      rf_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (grant_s)
        GRANT_EXU: begin
          rf_wen_r <= (exu_rd != RD_ZERO);
          if (exu_rd != RD_ZERO) begin
            rf_rd_r    <= exu_rd;
            rf_wdata_r <= exu_wdata;
          end
        end
        GRANT_FIFO: begin
          rf_wen_r <= (head_rd_s != RD_ZERO);
          if (head_rd_s != RD_ZERO) begin
            rf_rd_r    <= head_rd_s;
            rf_wdata_r <= head_wdata_s;
          end
        end
        default: rf_wen_r <= 1'b0;
      endcase
    end
  end

  assign rf_wen   = rf_wen_r;
  assign rf_rd    = rf_rd_r;
  assign rf_wdata = rf_wdata_r;

`ifdef WB_BYPASS_EN
  assign fwd1_hit  = rf_wen_r && (rf_rd_r == rs1) && (rs1 != RD_ZERO);
  assign fwd1_data = rf_wdata_r;
  assign fwd2_hit  = rf_wen_r && (rf_rd_r == rs2) && (rs2 != RD_ZERO);
  assign fwd2_data = rf_wdata_r;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference of the arbitration rules.
module tb_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          exu_valid = 1'b0;
  logic [AW-1:0] exu_rd = '0;
  logic [DW-1:0] exu_wdata = '0;
  logic          lsu_valid = 1'b0;
  logic [AW-1:0] lsu_rd = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          exu_ready, lsu_ready, rf_wen, busy;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [AW-1:0] q_rd[$];
  logic [DW-1:0] q_wd[$];
  int            m_starve;
  logic          m_rf_wen;
  logic [AW-1:0] m_rf_rd;
  logic [DW-1:0] m_rf_wd;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_wdata(exu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
`ifdef WB_BYPASS_EN
    .rs1(rs1), .rs2(rs2), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
`endif
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit m_starved();
    return (q_rd.size() != 0) && (m_starve == LIMIT);
  endfunction

  function automatic logic [40:0] m_expect();
    return {rst_n && !m_starved(), rst_n && (q_rd.size() < DEPTH), q_rd.size() != 0,
            m_rf_wen, m_rf_rd, m_rf_wd};
  endfunction

  function automatic logic [40:0] dut_observe();
    return {exu_ready, lsu_ready, busy, rf_wen, rf_rd, rf_wdata};
  endfunction

  task automatic model_reset();
    q_rd.delete(); q_wd.delete();
    m_starve = 0; m_rf_wen = 1'b0; m_rf_rd = '0; m_rf_wd = '0;
  endtask

  // Advance the model by one clock using the current TB inputs.
  task automatic model_clock();
    bit was_empty, lsu_rdy;
    int win;
    logic [AW-1:0] w_rd;
    logic [DW-1:0] w_wd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_empty = (q_rd.size() == 0);
    lsu_rdy   = (q_rd.size() < DEPTH);
    if (m_starved())       win = 2;
    else if (exu_valid)    win = 1;
    else if (!was_empty)   win = 2;
    else                   win = 0;
    w_rd = '0; w_wd = '0;
    if (win == 1) begin w_rd = exu_rd; w_wd = exu_wdata; end
    if (win == 2) begin w_rd = q_rd.pop_front(); w_wd = q_wd.pop_front(); end
    m_rf_wen = (win != 0) && (w_rd != 0);
    if (m_rf_wen) begin m_rf_rd = w_rd; m_rf_wd = w_wd; end
    if (lsu_valid && lsu_rdy) begin q_rd.push_back(lsu_rd); q_wd.push_back(lsu_wdata); end
    if (was_empty || win == 2) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; lsu_valid = 1'b0; exu_rd = '0; lsu_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; exu_valid = 1'b1; lsu_valid = 1'b1; exu_rd = 5'd3; lsu_rd = 5'd4;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dut_observe() !== 41'd0) begin
        errors++;
        $display("FAIL reset[%0d] observed %h required %h", i, dut_observe(), 41'd0);
      end
      tick();
    end
    rst_n = 1'b1; idle_inputs();
    tick();
  endtask

  task automatic test_exu_basic();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_wdata = 32'h1234;
    @(negedge clk);
    checks++;
    if (exu_ready !== 1'b1) begin errors++; $display("FAIL exu_ready observed %b required 1", exu_ready); end
    tick();
    exu_rd = 5'd0; exu_wdata = 32'hFF;
    @(negedge clk);
    checks++;
    if ({rf_wen, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL exu_write observed %b/%0d/%h required 1/5/1234", rf_wen, rf_rd, rf_wdata);
    end
    checks++;
    if (exu_ready !== 1'b1) begin errors++; $display("FAIL exu_rd0_ready observed %b required 1", exu_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({rf_wen, rf_rd, rf_wdata} !== {1'b0, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL exu_rd0_write observed %b/%0d/%h required 0/5/1234", rf_wen, rf_rd, rf_wdata);
    end
    tick();
  endtask

  task automatic test_lsu_basic();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'hAA;
    @(negedge clk);
    checks++;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL lsu_ready observed %b required 1", lsu_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({busy, rf_wen} !== 2'b10) begin
      errors++; $display("FAIL lsu_latency1 observed busy=%b wen=%b required busy=1 wen=0", busy, rf_wen);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({busy, rf_wen, rf_rd, rf_wdata} !== {1'b0, 1'b1, 5'd7, 32'hAA}) begin
      errors++; $display("FAIL lsu_write observed %b/%b/%0d/%h required 0/1/7/aa", busy, rf_wen, rf_rd, rf_wdata);
    end
    tick();
  endtask

  task automatic test_starve();
    for (int i = 0; i < 10; i++) begin
      exu_valid = 1'b1; exu_rd = 5'($urandom_range(1, 31)); exu_wdata = $urandom;
      lsu_valid = (i == 0); lsu_rd = 5'd9; lsu_wdata = 32'h5A5A;
      @(negedge clk);
      checks++;
      if (dut_observe() !== m_expect()) begin
        errors++; $display("FAIL starve[%0d] observed %h required %h", i, dut_observe(), m_expect());
      end
      checks++;
      if (exu_ready !== (i != 5)) begin
        errors++; $display("FAIL starve_ready[%0d] observed %b required %b", i, exu_ready, i != 5);
      end
      if (i == 6) begin
        checks++;
        if ({rf_wen, rf_rd, rf_wdata} !== {1'b1, 5'd9, 32'h5A5A}) begin
          errors++; $display("FAIL starve_write observed %b/%0d/%h required 1/9/5a5a", rf_wen, rf_rd, rf_wdata);
        end
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seen[$];
    int sent = 0;
    for (int i = 0; i < 30; i++) begin
      exu_valid = 1'b1; exu_rd = 5'd1; exu_wdata = 32'hE000_0000 | 32'(i);
      lsu_valid = (sent < 3); lsu_rd = 5'(10 + sent); lsu_wdata = 32'hB0 + 32'(sent);
      @(negedge clk);
      checks++;
      if (dut_observe() !== m_expect()) begin
        errors++; $display("FAIL b2b[%0d] observed %h required %h", i, dut_observe(), m_expect());
      end
      if (i == 2) begin
        checks++;
        if (lsu_ready !== 1'b0) begin errors++; $display("FAIL b2b_full observed %b required 0", lsu_ready); end
      end
      if (rf_wen && rf_rd >= 5'd10) seen.push_back(rf_wdata);
      if (lsu_valid && q_rd.size() < DEPTH) sent++;
      tick();
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'hB0 || seen[1] !== 32'hB1 || seen[2] !== 32'hB2) begin
      errors++; $display("FAIL b2b_order observed %0d entries required b0,b1,b2", seen.size());
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      exu_valid = 1'b1; exu_rd = 5'd2; exu_wdata = 32'(i);
      lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_wdata = 32'hC0 + 32'(i);
      tick();
    end
    rst_n = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({exu_ready, lsu_ready, busy} !== 3'b001) begin
      errors++; $display("FAIL mid_reset_ready observed %b required 001", {exu_ready, lsu_ready, busy});
    end
    tick();
    rst_n = 1'b1; idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, rf_wen, rf_rd, rf_wdata} !== 39'd0) begin
        errors++; $display("FAIL mid_reset[%0d] observed %b/%b/%0d/%h required all zero", i, busy, rf_wen, rf_rd, rf_wdata);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      exu_valid = $urandom_range(0, 1) == 1;
      exu_rd    = 5'($urandom_range(0, 31));
      exu_wdata = $urandom;
      lsu_valid = $urandom_range(0, 2) != 0;
      lsu_rd    = 5'($urandom_range(0, 31));
      lsu_wdata = $urandom;
`ifdef WB_BYPASS_EN
      rs1 = $urandom_range(0, 1) ? m_rf_rd : 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
`endif
      @(negedge clk);
      checks++;
      if (dut_observe() !== m_expect()) begin
        errors++; $display("FAIL random[%0d] observed %h required %h", i, dut_observe(), m_expect());
      end
`ifdef WB_BYPASS_EN
      checks++;
      if ({fwd1_hit, fwd1_data, fwd2_hit} !== {m_rf_wen && m_rf_rd == rs1 && rs1 != 0, m_rf_wd,
                                                m_rf_wen && m_rf_rd == rs2 && rs2 != 0}) begin
        errors++; $display("FAIL bypass[%0d] observed %b/%h/%b", i, fwd1_hit, fwd1_data, fwd2_hit);
      end
`endif
      tick();
    end
    rst_n = 1'b1; idle_inputs();
    repeat (12) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exu_basic();
    test_lsu_basic();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
